loop_addr_gen: RTL and testbench

Nested-loop SRAM address generator for the memory controller. It consumes the per-level loop indices and turns them into a stream of on-chip buffer read addresses. The walk is three loop levels (inner, middle, outer), each with its own max and stride. Each level follows the same count semantics as the controller's loop counters. Addresses are delivered to the SRAM read port over a valid/ready handshake, with a last flag on the final beat and a one-cycle done pulse.

---
 rtl/loop_addr_gen.sv | 164 ++++++++++++++++
 tb/tb_loop_addr_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_addr_gen.sv
// Three-level nested-loop address generator: walks inner/middle/outer indices
// and streams base + out*out_pitch + mid*mid_pitch + in over valid/ready.
module loop_addr_gen #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] in_max,
  input  logic [DATA_WIDTH-1:0] mid_max,
  input  logic [DATA_WIDTH-1:0] out_max,
  input  logic [DATA_WIDTH-1:0] in_stride,
  input  logic [DATA_WIDTH-1:0] mid_stride,
  input  logic [DATA_WIDTH-1:0] out_stride,
  input  logic [ADDR_WIDTH-1:0] mid_pitch,
  input  logic [ADDR_WIDTH-1:0] out_pitch,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] in_idx, mid_idx, out_idx;

  logic [ADDR_WIDTH-1:0] base_q, mid_pitch_q, out_pitch_q;
  logic [DATA_WIDTH-1:0] in_max_q, mid_max_q, out_max_q;
  logic [DATA_WIDTH-1:0] in_stride_q, mid_stride_q, out_stride_q;

  logic                  in_term, mid_term, out_term, all_term;
  logic [DATA_WIDTH-1:0] in_nxt, mid_nxt, out_nxt;
  logic                  nxt_last;
  logic                  fire;

  // Terminal when past max, or when the next step would carry out of DATA_WIDTH.
  function automatic logic is_term(input logic [DATA_WIDTH-1:0] idx,
                                   input logic [DATA_WIDTH-1:0] mx,
                                   input logic [DATA_WIDTH-1:0] st);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, idx} + {1'b0, st};
    return (idx >= mx) || sum[DATA_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] step(input logic [DATA_WIDTH-1:0] idx,
                                                 input logic [DATA_WIDTH-1:0] st);
    return idx + st;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fix_stride(input logic [DATA_WIDTH-1:0] st);
    return (st == '0) ? DATA_WIDTH'(1) : st;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] widen(input logic [DATA_WIDTH-1:0] idx);
    return ADDR_WIDTH'(idx);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] calc_addr(input logic [DATA_WIDTH-1:0] o,
                                                      input logic [DATA_WIDTH-1:0] m,
                                                      input logic [DATA_WIDTH-1:0] i);
    return base_q + widen(o) * out_pitch_q + widen(m) * mid_pitch_q + widen(i);
  endfunction

  // Shadow copies of the walk configuration; only loaded on launch.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      base_q       <= base_addr;
      mid_pitch_q  <= mid_pitch;
      out_pitch_q  <= out_pitch;
      in_max_q     <= in_max;
      mid_max_q    <= mid_max;
      out_max_q    <= out_max;
      in_stride_q  <= fix_stride(in_stride);
      mid_stride_q <= fix_stride(mid_stride);
      out_stride_q <= fix_stride(out_stride);
    end
  end

  always_comb begin
    in_term  = is_term(in_idx, in_max_q, in_stride_q);
    mid_term = is_term(mid_idx, mid_max_q, mid_stride_q);
    out_term = is_term(out_idx, out_max_q, out_stride_q);
    all_term = in_term && mid_term && out_term;

    in_nxt  = in_term ? '0 : step(in_idx, in_stride_q);
    mid_nxt = mid_idx;
    out_nxt = out_idx;
    if (in_term)
      mid_nxt = mid_term ? '0 : step(mid_idx, mid_stride_q);
    if (in_term && mid_term)
      out_nxt = out_term ? '0 : step(out_idx, out_stride_q);

    nxt_last = is_term(in_nxt, in_max_q, in_stride_q) &&
               is_term(mid_nxt, mid_max_q, mid_stride_q) &&
               is_term(out_nxt, out_max_q, out_stride_q);
    fire = addr_valid && addr_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      in_idx     <= '0;
      mid_idx    <= '0;
      out_idx    <= '0;
      addr_valid <= 1'b0;
      addr       <= '0;
      addr_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= RUN;
            in_idx     <= '0;
            mid_idx    <= '0;
            out_idx    <= '0;
            addr_valid <= 1'b1;
            addr       <= base_addr;
            // From all-zero indices only a zero max can be terminal.
            addr_last  <= (in_max == '0) && (mid_max == '0) && (out_max == '0);
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (fire) begin
            in_idx  <= in_nxt;
            mid_idx <= mid_nxt;
            out_idx <= out_nxt;
            if (all_term) begin
              state      <= DONE;
              addr_valid <= 1'b0;
              addr       <= '0;
              addr_last  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              addr      <= calc_addr(out_nxt, mid_nxt, in_nxt);
              addr_last <= nxt_last;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          addr_valid <= 1'b0;
          addr_last  <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_addr_gen.sv
// Scoreboard bench for loop_addr_gen: expected beats are enumerated from the
// per-level sequences at launch and popped as the DUT transfers addresses.
module tb_loop_addr_gen;
  localparam int DW = 4;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [DW-1:0] in_max, mid_max, out_max;
  logic [DW-1:0] in_stride, mid_stride, out_stride;
  logic [AW-1:0] mid_pitch, out_pitch;
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] addr;
  logic          addr_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  loop_addr_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_max(in_max), .mid_max(mid_max), .out_max(out_max),
    .in_stride(in_stride), .mid_stride(mid_stride), .out_stride(out_stride),
    .mid_pitch(mid_pitch), .out_pitch(out_pitch),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .addr_last(addr_last), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic          l;
  } beat_t;
  typedef int iq_t[$];

  beat_t exp_q[$];
  int    exp_beats;
  int    errors = 0;
  int    checks = 0;

  logic          stall_prev = 1'b0;
  logic [AW-1:0] stall_addr;
  logic          stall_last;

  function automatic iq_t seq_of(input int mx, input int st);
    iq_t s;
    int  i;
    int  s1;
    bit  fin;
    s1  = (st == 0) ? 1 : st;
    i   = 0;
    fin = 0;
    while (!fin) begin
      s.push_back(i);
      if (i >= mx || i + s1 >= 16) fin = 1;
      else i = i + s1;
    end
    return s;
  endfunction

  // Transfer monitor: sampled mid-cycle, the beat moves on the following rising edge.
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && addr_valid) begin
        checks++;
        if (addr !== stall_addr || addr_last !== stall_last) begin
          errors++;
          $display("FAIL stall_hold: addr=%h last=%b required addr=%h last=%b",
                   addr, addr_last, stall_addr, stall_last);
        end
      end
      if (addr_valid && addr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: addr=%h last=%b, none required", addr, addr_last);
        end else begin
          e = exp_q.pop_front();
          if (addr !== e.a || addr_last !== e.l) begin
            errors++;
            $display("FAIL beat: addr=%h last=%b required addr=%h last=%b",
                     addr, addr_last, e.a, e.l);
          end
        end
      end
      stall_prev <= addr_valid && !addr_ready;
      stall_addr <= addr;
      stall_last <= addr_last;
    end
  end

  task automatic launch(input logic [AW-1:0] b, input int im, input int is,
                        input int mm, input int ms, input int om, input int os,
                        input logic [AW-1:0] mp, input logic [AW-1:0] op);
    iq_t   si, sm, so;
    beat_t e;
    int    cnt;
    @(posedge clk); #1;
    base_addr  = b;
    in_max     = DW'(im);  in_stride  = DW'(is);
    mid_max    = DW'(mm);  mid_stride = DW'(ms);
    out_max    = DW'(om);  out_stride = DW'(os);
    mid_pitch  = mp;       out_pitch  = op;
    si = seq_of(im, is);
    sm = seq_of(mm, ms);
    so = seq_of(om, os);
    exp_q.delete();
    exp_beats = si.size() * sm.size() * so.size();
    cnt = 0;
    foreach (so[o]) foreach (sm[m]) foreach (si[i]) begin
      cnt++;
      e.a = AW'(int'(b) + so[o] * int'(op) + sm[m] * int'(mp) + si[i]);
      e.l = (cnt == exp_beats);
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_walk(input bit rnd, input bit disturb);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) n++;
      if (disturb && k == 2) begin
        start = 1'b1; base_addr = 12'hFFF; in_max = 4'd7; in_stride = 4'd0;
      end
      if (disturb && k == 5) start = 1'b0;
      if (rnd) begin
        @(posedge clk); #1;
        addr_ready = 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done never seen within 300 cycles");
    end
    checks++;
    if (addr_valid !== 1'b0 || addr_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: valid=%b last=%b busy=%b required 0 0 0",
               addr_valid, addr_last, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL beats_left: %0d undelivered, required 0", exp_q.size());
    end
    if (!rnd) begin
      checks++;
      if (n != exp_beats) begin
        errors++;
        $display("FAIL busy_cycles: %0d required %0d", n, exp_beats);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b required 0 0", done, busy);
    end
    addr_ready = 1'b1;
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (addr_valid !== 1'b0 || addr !== '0 || addr_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%b addr=%h last=%b busy=%b done=%b required all 0",
               nm, addr_valid, addr, addr_last, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; addr_ready = 1'b1;
    base_addr = '0; in_max = '0; mid_max = '0; out_max = '0;
    in_stride = '0; mid_stride = '0; out_stride = '0;
    mid_pitch = '0; out_pitch = '0;
    #12;
    check_idle("reset_state");
    @(posedge clk); #3;
    reset = 1'b1;
    @(negedge clk);
    check_idle("idle_after_release");
  endtask

  task automatic test_basic();
    launch(12'h100, 3, 1, 1, 1, 0, 1, 12'h010, 12'h000);
    finish_walk(0, 0);
  endtask

  task automatic test_stride();
    launch(12'h040, 5, 2, 0, 1, 0, 1, 12'h000, 12'h000);
    finish_walk(0, 0);
    launch(12'h200, 15, 4, 0, 1, 0, 1, 12'h000, 12'h000);
    finish_walk(0, 0);
    launch(12'h300, 2, 0, 0, 1, 0, 1, 12'h000, 12'h000);
    finish_walk(0, 0);
  endtask

  task automatic test_backpressure();
    addr_ready = 1'($urandom_range(0, 1));
    launch(12'h100, 3, 1, 1, 1, 0, 1, 12'h010, 12'h000);
    finish_walk(1, 0);
  endtask

  task automatic test_config_isolation();
    launch(12'h100, 3, 1, 1, 1, 0, 1, 12'h010, 12'h000);
    finish_walk(0, 1);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || addr_valid !== 1'b0) begin
        errors++;
        $display("FAIL ignored_start: busy=%b valid=%b required 0 0", busy, addr_valid);
      end
    end
  endtask

  task automatic test_degenerate();
    launch(12'h02A, 0, 0, 0, 0, 0, 0, 12'h010, 12'h100);
    finish_walk(0, 0);
  endtask

  task automatic test_back_to_back();
    launch(12'hFF0, 1, 1, 2, 0, 1, 1, 12'h008, 12'h020);
    finish_walk(0, 0);
    launch(12'h7F0, 3, 3, 4, 2, 2, 2, 12'h040, 12'h400);
    finish_walk(0, 0);
  endtask

  task automatic test_async_reset();
    launch(12'h100, 3, 1, 1, 1, 0, 1, 12'h010, 12'h000);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_idle("async_reset_now");
    exp_q.delete();
    @(posedge clk); #3;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet: done=%b busy=%b valid=%b required 0 0 0",
                 done, busy, addr_valid);
      end
    end
    launch(12'h100, 3, 1, 1, 1, 0, 1, 12'h010, 12'h000);
    finish_walk(0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_backpressure();
    test_config_isolation();
    test_degenerate();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
